// File: rtl/ddr5_cmd_sched.sv
// DDR5 command scheduler: arbitrates read/write requests onto a single command port,
// tracks one open row, enforces tRP/tRCD/tRFC and issues periodic refresh.
module ddr5_cmd_sched #(
  parameter int ADDR_W  = 32,
  parameter int ROW_LSB = 12,
  parameter int TRCD    = 4,
  parameter int TRP     = 3,
  parameter int TRFC    = 8,
  parameter int TREFI   = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  output logic              wr_req_ready,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ready,
  input  logic              wdata_readable,
  output logic              wdata_re,
  output logic              cmd_valid,
  output logic [2:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  output logic              busy
);

  localparam int ROW_W  = ADDR_W - ROW_LSB;
  localparam int TMAX   = (TRFC > TRCD) ? ((TRFC > TRP) ? TRFC : TRP) : ((TRCD > TRP) ? TRCD : TRP);
  localparam int CNT_W  = $clog2(TMAX + 1);
  localparam int REFI_W = (TREFI > 2) ? $clog2(TREFI) : 1;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_REF = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_TRP_WAIT, S_ACT, S_TRCD_WAIT, S_RW, S_REF, S_TRFC_WAIT
  } state_t;

  state_t              state, nxt;
  logic                row_open;
  logic [ROW_W-1:0]    open_row;
  logic                last_wr;
  logic                req_vld;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_addr;
  logic [REFI_W-1:0]   refi_cnt;
  logic                ref_pending;
  logic [CNT_W-1:0]    wait_cnt;

  logic                wr_elig, rd_elig, refi_wrap, ref_due, grant, grant_wr, cmd_fire, wait_done;
  logic [ADDR_W-1:0]   grant_addr;
  logic [ROW_W-1:0]    grant_row;

  assign wr_elig    = wr_req_valid & wdata_readable;
  assign rd_elig    = rd_req_valid;
  assign refi_wrap  = (refi_cnt == REFI_W'(TREFI - 1));
  // a refresh coming due this cycle already blocks grants, so a racing request waits
  assign ref_due    = ref_pending | refi_wrap;
  assign grant      = (state == S_IDLE) & ~ref_due & (wr_elig | rd_elig);
  assign grant_wr   = wr_elig & (~rd_elig | ~last_wr);
  assign grant_addr = grant_wr ? wr_req_addr : rd_req_addr;
  assign grant_row  = grant_addr[ADDR_W-1:ROW_LSB];
  assign cmd_fire   = cmd_valid & cmd_ready;
  // counter holds T-1 on entry; leaving as it reaches 0 gives exactly T cycles to next valid
  assign wait_done  = (wait_cnt <= CNT_W'(1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (ref_due)    nxt = row_open ? S_PRE : S_REF;
        else if (grant) nxt = !row_open ? S_ACT : ((grant_row == open_row) ? S_RW : S_PRE);
      end
      S_PRE:       if (cmd_fire)  nxt = S_TRP_WAIT;
      S_TRP_WAIT:  if (wait_done) nxt = req_vld ? S_ACT : S_REF;
      S_ACT:       if (cmd_fire)  nxt = S_TRCD_WAIT;
      S_TRCD_WAIT: if (wait_done) nxt = S_RW;
      S_RW:        if (cmd_fire)  nxt = S_IDLE;
      S_REF:       if (cmd_fire)  nxt = S_TRFC_WAIT;
      S_TRFC_WAIT: if (wait_done) nxt = S_IDLE;
      default:                    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid    = 1'b0;
    cmd_op       = OP_NOP;
    cmd_addr     = '0;
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    wdata_re     = 1'b0;
    busy         = 1'b0;
    if (!sys_rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_PRE: begin
          cmd_valid = 1'b1;
          cmd_op    = OP_PRE;
        end
        S_ACT: begin
          cmd_valid = 1'b1;
          cmd_op    = OP_ACT;
          cmd_addr  = {req_addr[ADDR_W-1:ROW_LSB], {ROW_LSB{1'b0}}};
        end
        S_RW: begin
          cmd_valid    = 1'b1;
          cmd_op       = req_wr ? OP_WR : OP_RD;
          cmd_addr     = req_addr;
          rd_req_ready = cmd_ready & ~req_wr;
          wr_req_ready = cmd_ready & req_wr;
          wdata_re     = cmd_ready & req_wr;
        end
        S_REF: begin
          cmd_valid = 1'b1;
          cmd_op    = OP_REF;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_open    <= 1'b0;
      open_row    <= '0;
      last_wr     <= 1'b0;
      req_vld     <= 1'b0;
      req_wr      <= 1'b0;
      req_addr    <= '0;
      refi_cnt    <= '0;
      ref_pending <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      refi_cnt <= refi_wrap ? '0 : refi_cnt + REFI_W'(1);
      if (refi_wrap)                        ref_pending <= 1'b1;
      else if (state == S_REF && cmd_fire)  ref_pending <= 1'b0;

      if (grant) begin
        req_vld  <= 1'b1;
        req_wr   <= grant_wr;
        req_addr <= grant_addr;
        last_wr  <= grant_wr;
      end

      case (state)
        S_PRE: if (cmd_fire) begin
          row_open <= 1'b0;
          wait_cnt <= CNT_W'(TRP - 1);
        end
        S_ACT: if (cmd_fire) begin
          row_open <= 1'b1;
          open_row <= req_addr[ADDR_W-1:ROW_LSB];
          wait_cnt <= CNT_W'(TRCD - 1);
        end
        S_RW:  if (cmd_fire) req_vld <= 1'b0;
        S_REF: if (cmd_fire) wait_cnt <= CNT_W'(TRFC - 1);
        S_TRP_WAIT, S_TRCD_WAIT, S_TRFC_WAIT:
          if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
